seg7_scan_ctrl: RTL
===================

// Module: seg7_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
//  Holds a hex display word and steps one digit at a time onto a shared 4-bit bus
//  that feeds the single hex-to-7-segment decoder, with the matching anode enable.
//  New words update only at frame boundaries, so the display never shows a mix of
//  old and new digits. Also provides leading-zero blanking and 16-level PWM brightness.
// PARAMETERS
//  N_DIGITS    4      number of digits scanned (2..8)
//  CLK_DIV     50000  clk cycles per digit slot; must be a multiple of 16 and >= 16
//  AN_ACT_LOW  1      1: anode enable is active-low; 0: active-high
// PORTS
//  clk         in   1           system clock
//  reset       in   1           synchronous, active-high
//  value_in    in   4*N_DIGITS  hex word; nibble 0 (bits 3:0) is the rightmost digit
//  load        in   1           1-cycle strobe: capture value_in
//  dp_in       in   N_DIGITS    decimal-point enable per digit, sampled with value_in
//  lz_en       in   1           1: blank leading zeros
//  bright      in   4           duty code; 0 = dark, 15 = full on
//  bcd_out     out  4           digit code to the shared decoder
//  anode       out  N_DIGITS    one-hot digit enable (polarity set by AN_ACT_LOW)
//  dp_out      out  1           decimal point for the active digit, active-low
//  frame_done  out  1           1-cycle pulse when the last digit slot ends
// BEHAVIOUR
//  Reset: timer=0, idx=0, disp/pend/dp regs=0, pend_v=0, bcd_out=0,
//   anode=all inactive, dp_out=1, frame_done=0.
//  Timer: counts 0..CLK_DIV-1 and wraps. At wrap (tc), idx increments.
//   idx==N_DIGITS-1 at tc -> idx goes to 0, and frame_done=1 in the next cycle.
//  Load: load=1 captures value_in/dp_in into pend and sets pend_v. If load repeats
//   before the frame wrap, the last load wins.
//  Frame wrap (tc with idx==N_DIGITS-1):
//   - load=1 in the same cycle: disp takes value_in directly.
//   - else if pend_v: disp takes pend.
//   - In both cases pend_v clears.
//  Blanking: digit i is blank when lz_en=1, i>0, and nibbles N_DIGITS-1..i of disp
//   are all 0. Digit 0 is never blanked.
//  PWM: on_len = CLK_DIV when bright==15, else bright*(CLK_DIV/16).
//   The digit is lit while timer < on_len and it is not blanked.
//  Outputs: registered, 1-cycle latency from the idx/timer state.
//   bcd_out=disp nibble[idx]; dp_out=~dp[idx]; anode=one-hot(idx) when lit, else
//   all inactive. When AN_ACT_LOW=1, anode is inverted.
//  Exactly one anode bit may be active at any time; never more than one.
//  bcd_out keeps its nibble while the digit is dark; only anode gates the display.
//  A mid-operation reset drops any pending load and restarts at idx 0 with a dark
//   display.
// TESTING
//  (CLK_DIV=16, N_DIGITS=4, AN_ACT_LOW=1)
//  1. Reset, then load 16'h12AF, bright=15, lz_en=0 -> after the first wrap, bcd_out
//     cycles F,A,2,1; anode cycles 1110,1101,1011,0111, 16 clk each; frame_done
//     pulses every 64 clk.
//  2. Load 16'h1234 mid-frame -> the remaining slots still show the old word; the
//     new word appears starting at idx 0 after the wrap.
//  3. Load 16'h0007, lz_en=1 -> digits 3..1 have anode=1111 (dark); digit 0 is
//     lit with bcd 7. Load 16'h0000 -> only digit 0 is lit, showing 0.
//  4. bright=4 -> anode active for 4 of 16 clk per slot; bright=0 -> anode stays
//     1111 throughout.
//  5. Two loads (16'hAAAA, then 16'hBBBB) before the wrap -> 16'hBBBB is shown.
//     Load asserted on the wrap cycle -> that value is shown in the new frame.
//  6. Assert reset mid-frame with a load pending -> outputs return to reset values
//     next cycle, and the pending word is never displayed.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Scan controller for an N-digit common-anode 7-segment display. A display word
//   is held in a register and presented one digit at a time on a shared 4-bit bus
//   that feeds a single hex-to-7-segment decoder. The matching anode enable is
//   driven with the digit. New words are staged and only take effect at frame
//   boundaries, so a frame never shows a mix of old and new digits. The block also
//   does leading-zero blanking and 16-level PWM brightness.
//
// Parameters
//   N_DIGITS    number of digits scanned (2..8)
//   CLK_DIV     clk cycles per digit slot (a multiple of 16, >= 16)
//   AN_ACT_LOW  1: anode enables are active-low, 0: active-high
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high
//   value_in    hex word, nibble 0 (bits 3:0) is the rightmost digit
//   load        1-cycle strobe that captures value_in / dp_in
//   dp_in       per-digit decimal-point enables, captured with value_in
//   lz_en       1: blank leading zeros
//   bright      duty code, 0 = dark, 15 = always on
//   bcd_out     digit code for the shared decoder
//   anode       one-hot digit enable (polarity per AN_ACT_LOW)
//   dp_out      decimal point of the active digit, active-low
//   frame_done  1-cycle pulse after the last digit slot ends
module seg7_scan_ctrl #(
    parameter int N_DIGITS   = 4,
    parameter int CLK_DIV    = 50000,
    parameter bit AN_ACT_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] value_in,
    input  logic                  load,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  lz_en,
    input  logic [3:0]            bright,
    output logic [3:0]            bcd_out,
    output logic [N_DIGITS-1:0]   anode,
    output logic                  dp_out,
    output logic                  frame_done
);

    localparam int TW = $clog2(CLK_DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam int VW = 4 * N_DIGITS;

    localparam logic [TW-1:0]       TC_VAL   = TW'(CLK_DIV - 1);
    localparam logic [TW:0]         ON_FULL  = (TW + 1)'(CLK_DIV);
    localparam logic [TW:0]         SLICE    = (TW + 1)'(CLK_DIV / 16);
    localparam logic [IW-1:0]       LAST_IDX = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{AN_ACT_LOW}};

    // Number of timer ticks per slot during which the digit is lit. Code 15 is
    // stretched to the full slot so "full on" has no dark gap.
    function automatic logic [TW:0] pwm_on_len(input logic [3:0] code);
        if (code == 4'hF) begin
            return ON_FULL;
        end
        return (TW + 1)'(code) * SLICE;
    endfunction

    logic [TW-1:0]       timer_q, timer_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [VW-1:0]       disp_q, disp_d;
    logic [VW-1:0]       pend_q, pend_d;
    logic [N_DIGITS-1:0] dp_disp_q, dp_disp_d;
    logic [N_DIGITS-1:0] dp_pend_q, dp_pend_d;
    logic                pend_v_q, pend_v_d;
    logic [3:0]          bcd_q, bcd_d;
    logic [N_DIGITS-1:0] anode_q, anode_d;
    logic                dp_out_q, dp_out_d;
    logic                frame_done_q, frame_done_d;

    logic                tc;
    logic                wrap;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic                hi_zero;
    logic                lit;
    logic [N_DIGITS-1:0] onehot;

    // Slot timer, digit index and the staged/displayed word registers.
    always_comb begin
        tc   = (timer_q == TC_VAL);
        wrap = tc && (idx_q == LAST_IDX);

        timer_d = tc ? '0 : timer_q + 1'b1;
        idx_d   = idx_q;
        if (tc) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end

        pend_d    = pend_q;
        dp_pend_d = dp_pend_q;
        pend_v_d  = pend_v_q;
        if (load) begin
            pend_d    = value_in;
            dp_pend_d = dp_in;
            pend_v_d  = 1'b1;
        end

        disp_d    = disp_q;
        dp_disp_d = dp_disp_q;
        if (wrap) begin
            // A load landing on the wrap cycle bypasses the staging register,
            // otherwise it would be lost when pend_v clears below.
            if (load) begin
                disp_d    = value_in;
                dp_disp_d = dp_in;
            end else if (pend_v_q) begin
                disp_d    = pend_q;
                dp_disp_d = dp_pend_q;
            end
            pend_v_d = 1'b0;
        end

        frame_done_d = wrap;
    end

    // Active digit select, leading-zero blanking and PWM gating.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        onehot    = '0;
        hi_zero   = 1'b1;
        // Walk from the most significant digit down; hi_zero stays set while
        // every nibble from the top through digit i is zero.
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            hi_zero = hi_zero && (disp_q[4*i +: 4] == 4'h0);
            if (idx_q == IW'(i)) begin
                cur_nib   = disp_q[4*i +: 4];
                cur_dp    = dp_disp_q[i];
                cur_blank = lz_en && (i > 0) && hi_zero;
                onehot[i] = 1'b1;
            end
        end

        lit      = ({1'b0, timer_q} < pwm_on_len(bright)) && !cur_blank;
        bcd_d    = cur_nib;
        dp_out_d = ~cur_dp;
        anode_d  = AN_OFF;
        if (lit) begin
            anode_d = AN_ACT_LOW ? ~onehot : onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q      <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            dp_disp_q    <= '0;
            dp_pend_q    <= '0;
            pend_v_q     <= 1'b0;
            bcd_q        <= 4'h0;
            anode_q      <= AN_OFF;
            dp_out_q     <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            timer_q      <= timer_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            dp_disp_q    <= dp_disp_d;
            dp_pend_q    <= dp_pend_d;
            pend_v_q     <= pend_v_d;
            bcd_q        <= bcd_d;
            anode_q      <= anode_d;
            dp_out_q     <= dp_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bcd_out    = bcd_q;
    assign anode      = anode_q;
    assign dp_out     = dp_out_q;
    assign frame_done = frame_done_q;

endmodule
